// File: rtl/hpu_prf_wb_ctrl.sv
// PRF writeback controller: buffers producer results in per-channel 2-entry
// FIFOs, round-robins FIFO heads onto registered PRF write ports and keeps
// the per-register busy scoreboard used by issue wakeup.
module hpu_prf_wb_ctrl #(
    parameter int unsigned NUM_SRC   = 6,
    parameter int unsigned NUM_WR    = 4,
    parameter int unsigned IDX_W     = 7,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_ALLOC = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_SRC-1:0]         src_vld_i,
    output logic [NUM_SRC-1:0]         src_rdy_o,
    input  logic [NUM_SRC*IDX_W-1:0]   src_idx_i,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data_i,
    output logic [NUM_WR-1:0]          prf_wr_en_o,
    output logic [NUM_WR*IDX_W-1:0]    prf_wr_addr_o,
    output logic [NUM_WR*DATA_W-1:0]   prf_wr_data_o,
    input  logic [NUM_ALLOC-1:0]       alloc_en_i,
    input  logic [NUM_ALLOC*IDX_W-1:0] alloc_idx_i,
    input  logic                       flush_i,
    output logic [(2**IDX_W)-1:0]      prf_rdy_vec_o
);

    localparam int unsigned NUM_PREG = 2 ** IDX_W;
    localparam int unsigned PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Per-channel FIFO storage and control
    logic [IDX_W-1:0]   fifo_idx  [NUM_SRC][2];
    logic [DATA_W-1:0]  fifo_data [NUM_SRC][2];
    logic [1:0]         fifo_cnt  [NUM_SRC];
    logic [NUM_SRC-1:0] fifo_rd;
    logic [NUM_SRC-1:0] wr_slot;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] nonempty;
    logic [IDX_W-1:0]   head_idx  [NUM_SRC];
    logic [DATA_W-1:0]  head_data [NUM_SRC];

    // Arbitration
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_nxt;
    logic [NUM_SRC-1:0] gnt;
    int                 scan_pos  [NUM_SRC];
    int                 scan_rank [NUM_SRC];
    int                 last_pos;
    logic [NUM_WR-1:0]  port_vld;
    logic [IDX_W-1:0]   port_idx  [NUM_WR];
    logic [DATA_W-1:0]  port_data [NUM_WR];

    // Registered write ports
    logic [NUM_WR-1:0]  wr_en;
    logic [IDX_W-1:0]   wr_addr [NUM_WR];
    logic [DATA_W-1:0]  wr_data [NUM_WR];

    // Scoreboard, stored as ready (= not busy) so the output is a flop
    logic [NUM_PREG-1:0] rdy_vec;
    logic [NUM_PREG-1:0] busy;
    logic [NUM_PREG-1:0] busy_nxt;

    // Handshake and FIFO head decode; ready looks only at the registered count
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rdy_o[i] = (fifo_cnt[i] < 2'd2) & rst_i;
            push[i]      = src_vld_i[i] & src_rdy_o[i] & ~flush_i;
            nonempty[i]  = (fifo_cnt[i] != 2'd0);
            wr_slot[i]   = fifo_rd[i] ^ fifo_cnt[i][0];
            head_idx[i]  = fifo_idx[i][fifo_rd[i]];
            head_data[i] = fifo_data[i][fifo_rd[i]];
        end
    end

    // Round-robin: rank each non-empty channel by its distance from rr_ptr;
    // the first NUM_WR ranks win and rank selects the write port.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_pos[i] = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr))
                                              : (i + int'(NUM_SRC) - int'(rr_ptr));
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_rank[i] = 0;
            for (int j = 0; j < NUM_SRC; j++) begin
                if (nonempty[j] && (scan_pos[j] < scan_pos[i])) begin
                    scan_rank[i] = scan_rank[i] + 1;
                end
            end
            gnt[i] = nonempty[i] && (scan_rank[i] < int'(NUM_WR));
        end
        // Pointer moves just past the last channel granted in scan order
        rr_nxt   = rr_ptr;
        last_pos = -1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i] && (scan_pos[i] > last_pos)) begin
                last_pos = scan_pos[i];
                rr_nxt   = (i == int'(NUM_SRC) - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        for (int p = 0; p < NUM_WR; p++) begin
            port_vld[p]  = 1'b0;
            port_idx[p]  = '0;
            port_data[p] = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt[i] && (scan_rank[i] == p)) begin
                    port_vld[p]  = 1'b1;
                    port_idx[p]  = head_idx[i];
                    port_data[p] = head_data[i];
                end
            end
        end
    end

    // Scoreboard next state: writeback clears first so a same-edge allocation wins
    always_comb begin
        busy_nxt = busy;
        for (int p = 0; p < NUM_WR; p++) begin
            if (port_vld[p]) begin
                busy_nxt[port_idx[p]] = 1'b0;
            end
        end
        for (int j = 0; j < NUM_ALLOC; j++) begin
            if (alloc_en_i[j]) begin
                busy_nxt[alloc_idx_i[j*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        // Register 0 is never tracked as busy
        busy_nxt[0] = 1'b0;
    end

    assign busy = ~rdy_vec;

    // FIFO occupancy and head pointer
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fifo_cnt[i] <= 2'd0;
            end
            fifo_rd <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i] && !gnt[i]) begin
                    fifo_cnt[i] <= fifo_cnt[i] + 2'd1;
                end else if (!push[i] && gnt[i]) begin
                    fifo_cnt[i] <= fifo_cnt[i] - 2'd1;
                end
                if (gnt[i]) begin
                    fifo_rd[i] <= ~fifo_rd[i];
                end
            end
        end
    end

    // FIFO payload; only read once its count covers the slot, so no reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                fifo_idx[i][wr_slot[i]]  <= src_idx_i[i*IDX_W +: IDX_W];
                fifo_data[i][wr_slot[i]] <= src_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered PRF write ports; idle ports keep their last addr/data
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_en <= '0;
            for (int p = 0; p < NUM_WR; p++) begin
                wr_addr[p] <= '0;
                wr_data[p] <= '0;
            end
        end else if (flush_i) begin
            wr_en <= '0;
        end else begin
            wr_en <= port_vld;
            for (int p = 0; p < NUM_WR; p++) begin
                if (port_vld[p]) begin
                    wr_addr[p] <= port_idx[p];
                    wr_data[p] <= port_data[p];
                end
            end
        end
    end

    // Round-robin pointer and scoreboard; flush frees everything but keeps rr_ptr
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rr_ptr  <= '0;
            rdy_vec <= '1;
        end else if (flush_i) begin
            rdy_vec <= '1;
        end else begin
            rr_ptr  <= rr_nxt;
            rdy_vec <= ~busy_nxt;
        end
    end

    // Flatten write ports onto the output buses
    always_comb begin
        prf_wr_en_o   = wr_en;
        prf_rdy_vec_o = rdy_vec;
        for (int p = 0; p < NUM_WR; p++) begin
            prf_wr_addr_o[p*IDX_W +: IDX_W]   = wr_addr[p];
            prf_wr_data_o[p*DATA_W +: DATA_W] = wr_data[p];
        end
    end

    // Illegal-use detection: duplicate allocation in one cycle
    logic alloc_dup;
    always_comb begin
        alloc_dup = 1'b0;
        for (int j = 0; j < NUM_ALLOC; j++) begin
            for (int k = j + 1; k < NUM_ALLOC; k++) begin
                if (alloc_en_i[j] && alloc_en_i[k] &&
                    (alloc_idx_i[j*IDX_W +: IDX_W] == alloc_idx_i[k*IDX_W +: IDX_W]) &&
                    (alloc_idx_i[j*IDX_W +: IDX_W] != '0)) begin
                    alloc_dup = 1'b1;
                end
            end
        end
    end

    // Illegal-use detection: two live FIFO entries targeting the same register
    logic live [NUM_SRC][2];
    logic fifo_dup;
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int s = 0; s < 2; s++) begin
                live[i][s] = (fifo_cnt[i] == 2'd2) ||
                             ((fifo_cnt[i] == 2'd1) && (fifo_rd[i] == 1'(s)));
            end
        end
        fifo_dup = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int s = 0; s < 2; s++) begin
                for (int j = 0; j < NUM_SRC; j++) begin
                    for (int t = 0; t < 2; t++) begin
                        if (((i * 2 + s) < (j * 2 + t)) && live[i][s] && live[j][t] &&
                            (fifo_idx[i][s] == fifo_idx[j][t])) begin
                            fifo_dup = 1'b1;
                        end
                    end
                end
            end
        end
    end

    a_no_alloc_dup: assert property (@(posedge clk_i) disable iff (!rst_i) !alloc_dup);
    a_no_fifo_dup:  assert property (@(posedge clk_i) disable iff (!rst_i) !fifo_dup);

endmodule

// File: tb/tb_hpu_prf_wb_ctrl.sv
// Bench for hpu_prf_wb_ctrl: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_hpu_prf_wb_ctrl;

    localparam int NS = 6;
    localparam int NW = 4;
    localparam int IW = 7;
    localparam int DW = 32;
    localparam int NA = 2;
    localparam int NP = 128;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NS-1:0]    src_vld;
    logic [NS-1:0]    src_rdy;
    logic [NS*IW-1:0] src_idx;
    logic [NS*DW-1:0] src_data;
    logic [NW-1:0]    wr_en;
    logic [NW*IW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NA-1:0]    alloc_en;
    logic [NA*IW-1:0] alloc_idx;
    logic             flush;
    logic [NP-1:0]    rdy_vec;

    always #5 clk = ~clk;

    hpu_prf_wb_ctrl #(
        .NUM_SRC  (NS),
        .NUM_WR   (NW),
        .IDX_W    (IW),
        .DATA_W   (DW),
        .NUM_ALLOC(NA)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .src_vld_i    (src_vld),
        .src_rdy_o    (src_rdy),
        .src_idx_i    (src_idx),
        .src_data_i   (src_data),
        .prf_wr_en_o  (wr_en),
        .prf_wr_addr_o(wr_addr),
        .prf_wr_data_o(wr_data),
        .alloc_en_i   (alloc_en),
        .alloc_idx_i  (alloc_idx),
        .flush_i      (flush),
        .prf_rdy_vec_o(rdy_vec)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: one queue per channel, busy bit array, expected ports
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq [NS][$];
    logic [NP-1:0] m_busy = '0;
    logic [NW-1:0] m_en   = '0;
    logic [IW-1:0] m_addr [NW];
    logic [DW-1:0] m_data [NW];
    int            m_rr   = 0;
    int            m_push = 0;
    int            dut_wr = 0;
    bit            chk_on = 1'b0;

    task automatic model_step();
        int   sz  [NS];
        int   gch [NW];
        int   ng;
        int   ch;
        ent_t e;
        if (!rst_i) begin
            for (int c = 0; c < NS; c++) mq[c].delete();
            m_rr   = 0;
            m_en   = '0;
            m_busy = '0;
            for (int p = 0; p < NW; p++) begin
                m_addr[p] = '0;
                m_data[p] = '0;
            end
        end else begin
            ng = 0;
            for (int c = 0; c < NS; c++) sz[c] = mq[c].size();
            for (int k = 0; k < NS; k++) begin
                ch = (m_rr + k) % NS;
                if (sz[ch] > 0 && ng < NW) begin
                    gch[ng] = ch;
                    ng++;
                end
            end
            if (flush) begin
                for (int c = 0; c < NS; c++) mq[c].delete();
                m_en   = '0;
                m_busy = '0;
            end else begin
                for (int p = 0; p < NW; p++) begin
                    if (p < ng) begin
                        e         = mq[gch[p]].pop_front();
                        m_en[p]   = 1'b1;
                        m_addr[p] = e.idx;
                        m_data[p] = e.data;
                        m_busy[e.idx] = 1'b0;
                    end else begin
                        m_en[p] = 1'b0;
                    end
                end
                if (ng > 0) m_rr = (gch[ng-1] + 1) % NS;
                for (int j = 0; j < NA; j++) begin
                    if (alloc_en[j] && alloc_idx[j*IW +: IW] != 0)
                        m_busy[alloc_idx[j*IW +: IW]] = 1'b1;
                end
                for (int c = 0; c < NS; c++) begin
                    if (src_vld[c] && sz[c] < 2) begin
                        e.idx  = src_idx[c*IW +: IW];
                        e.data = src_data[c*DW +: DW];
                        mq[c].push_back(e);
                        m_push++;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every output against the model on each falling edge
    initial forever begin
        logic [NS-1:0]    e_rdy;
        logic [NW*IW-1:0] e_addr;
        logic [NW*DW-1:0] e_data;
        @(negedge clk);
        if (chk_on) begin
            for (int c = 0; c < NS; c++) e_rdy[c] = rst_i && (mq[c].size() < 2);
            for (int p = 0; p < NW; p++) begin
                e_addr[p*IW +: IW] = m_addr[p];
                e_data[p*DW +: DW] = m_data[p];
            end
            chk("model_src_rdy", src_rdy, e_rdy);
            chk("model_wr_en", wr_en, m_en);
            chk("model_wr_addr", wr_addr, e_addr);
            chk("model_wr_data", wr_data, e_data);
            chk("model_rdy_vec", rdy_vec, ~m_busy);
            dut_wr += $countones(wr_en);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        src_vld  = '0;
        alloc_en = '0;
        flush    = 1'b0;
    endtask

    task automatic put(input int ch, input logic [IW-1:0] idx, input logic [DW-1:0] d);
        src_vld[ch]            = 1'b1;
        src_idx[ch*IW +: IW]   = idx;
        src_data[ch*DW +: DW]  = d;
    endtask

    task automatic alloc(input int j, input logic [IW-1:0] idx);
        alloc_en[j]              = 1'b1;
        alloc_idx[j*IW +: IW]    = idx;
    endtask

    logic [IW-1:0] ctr = 7'd60;
    logic [NP-1:0] all_ones;
    bit            saw_low;
    int            w0;
    int            p0;

    initial begin
        all_ones  = '1;
        rst_i     = 1'b0;
        src_vld   = '1;
        src_idx   = '0;
        src_data  = '0;
        alloc_en  = '0;
        alloc_idx = '0;
        flush     = 1'b0;
        step();
        chk_on = 1'b1;

        // Reset held with all producers valid
        repeat (3) begin
            @(negedge clk);
            chk("rst_src_rdy", src_rdy, 6'h00);
            chk("rst_wr_en", wr_en, 4'h0);
            chk("rst_rdy_vec", rdy_vec, all_ones);
            step();
        end
        rst_i   = 1'b1;
        src_vld = '0;
        @(negedge clk);
        chk("rel_src_rdy", src_rdy, 6'h3F);
        step();

        // Single path: allocate 5, channel 2 writes it back
        alloc(0, 7'd5);
        step();
        quiet();
        @(negedge clk);
        chk("sp_busy5", rdy_vec[5], 1'b0);
        step();
        step();
        put(2, 7'd5, 32'hDEADBEEF);
        step();
        quiet();
        step();
        @(negedge clk);
        chk("sp_en", wr_en, 4'b0001);
        chk("sp_addr0", wr_addr[IW-1:0], 7'd5);
        chk("sp_data0", wr_data[DW-1:0], 32'hDEADBEEF);
        chk("sp_rdy5", rdy_vec[5], 1'b1);
        step();

        // Bring rr_ptr back to 0 by serving channel 5 alone
        put(5, 7'd9, 32'h0000_0009);
        step();
        quiet();
        step();
        step();

        // Round-robin: all channels push at once
        for (int c = 0; c < NS; c++) put(c, 7'(10 + c), 32'hA000_0000 + 32'(c));
        step();
        quiet();
        step();
        @(negedge clk);
        chk("rr_en1", wr_en, 4'hF);
        chk("rr_addr1", wr_addr, {7'd13, 7'd12, 7'd11, 7'd10});
        chk("rr_data3", wr_data[3*DW +: DW], 32'hA000_0003);
        step();
        @(negedge clk);
        chk("rr_en2", wr_en, 4'b0011);
        chk("rr_addr2", wr_addr, {7'd13, 7'd12, 7'd15, 7'd14});
        step();
        // rr_ptr back at 0: channel 0 must beat channel 5 for port 0
        put(0, 7'd30, 32'h3030_3030);
        put(5, 7'd31, 32'h3131_3131);
        step();
        quiet();
        step();
        @(negedge clk);
        chk("rr_wrap_en", wr_en, 4'b0011);
        chk("rr_wrap_addr0", wr_addr[IW-1:0], 7'd30);
        chk("rr_wrap_addr1", wr_addr[2*IW-1:IW], 7'd31);
        step();

        // Allocation and writeback of 20 on the same edge
        alloc(0, 7'd20);
        put(1, 7'd20, 32'h2020_2020);
        step();
        src_vld = '0;
        @(negedge clk);
        chk("race_busy_pre", rdy_vec[20], 1'b0);
        step();
        quiet();
        @(negedge clk);
        chk("race_en", wr_en, 4'b0001);
        chk("race_addr", wr_addr[IW-1:0], 7'd20);
        chk("race_data", wr_data[DW-1:0], 32'h2020_2020);
        chk("race_busy_post", rdy_vec[20], 1'b0);
        step();

        // Flush with one write in flight and three entries buffered
        alloc(0, 7'd40);
        alloc(1, 7'd41);
        step();
        quiet();
        put(3, 7'd50, 32'h5050_5050);
        step();
        quiet();
        put(0, 7'd51, 32'h5151_5151);
        put(1, 7'd52, 32'h5252_5252);
        put(2, 7'd53, 32'h5353_5353);
        step();
        quiet();
        put(4, 7'd54, 32'h5454_5454);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_inflight_en", wr_en, 4'b0001);
        chk("fl_inflight_addr", wr_addr[IW-1:0], 7'd50);
        step();
        quiet();
        @(negedge clk);
        chk("fl_en_after", wr_en, 4'h0);
        chk("fl_rdy_vec", rdy_vec, all_ones);
        chk("fl_src_rdy", src_rdy, 6'h3F);
        step();
        @(negedge clk);
        chk("fl_en_after2", wr_en, 4'h0);
        step();

        // Saturation: every channel pushes every cycle
        w0      = dut_wr;
        p0      = m_push;
        saw_low = 1'b0;
        repeat (40) begin
            for (int c = 0; c < NS; c++) begin
                put(c, ctr, $urandom);
                ctr = ctr + 7'd1;
            end
            @(negedge clk);
            if (src_rdy[0] === 1'b0) saw_low = 1'b1;
            step();
        end
        quiet();
        repeat (6) step();
        chk("sat_rdy0_dropped", saw_low, 1'b1);
        chk("sat_lossless", 128'(dut_wr - w0), 128'(m_push - p0));

        // Random traffic with occasional flush and reset
        repeat (800) begin
            rst_i = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NS; c++) begin
                src_vld[c]            = $urandom_range(0, 1);
                src_idx[c*IW +: IW]   = ctr;
                src_data[c*DW +: DW]  = $urandom;
                ctr = ctr + 7'd1;
            end
            for (int j = 0; j < NA; j++) begin
                alloc_en[j]           = $urandom_range(0, 1);
                alloc_idx[j*IW +: IW] = 7'($urandom);
            end
            if (alloc_idx[IW-1:0] == alloc_idx[2*IW-1:IW]) alloc_en[1] = 1'b0;
            step();
        end
        rst_i = 1'b1;
        quiet();
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
